fu_scheduler: RTL and testbench
===============================

FU_SCHEDULER -- requirements
Module: fu_scheduler

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 1, cycles from issue to ALU result ready (range 1..15).
REQ-002 SHALL have parameter MUL_LATENCY, default 4, cycles from issue to MUL result ready (range 1..15).
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iss_valid  in  1  issue stage presents an instruction.
REQ-006 SHALL have port iss_unit  in  2  target unit: 0=ALU, 1=MEM, 2=MUL, 3=reserved.
REQ-007 SHALL have port iss_regdest  in  5  destination register of the issued instruction.
REQ-008 SHALL have port iss_writereg  in  1  instruction writes a register.
REQ-009 SHALL have port iss_accept  out  1  instruction taken this cycle (combinational).
REQ-010 SHALL have port iss_stall  out  1  iss_valid & ~iss_accept (combinational).
REQ-011 SHALL have port mem_done  in  1  MEM unit reports completion.
REQ-012 SHALL have port fu_busy  out  3  per-unit occupied flag, bit0=ALU, bit1=MEM, bit2=MUL (registered).
REQ-013 SHALL have port wb_valid  out  1  writeback slot granted this cycle (registered).
REQ-014 SHALL have port wb_unit  out  2  unit owning the writeback slot (registered).
REQ-015 SHALL have port wb_regdest  out  5  destination register for scoreboard clear (registered).
REQ-016 SHALL have port wb_writereg  out  1  scoreboard clear enable, qualified by wb_valid (registered).

Function
REQ-017 Per unit, state SHALL be one of IDLE, EXEC, DONE; fu_busy[u]=1 in EXEC or DONE.
REQ-018 iss_accept SHALL be 1 iff iss_valid=1, iss_unit!=3 and the target unit is IDLE in the current cycle.
REQ-019 iss_unit=3 SHALL never be accepted; iss_stall stays high while it is presented.
REQ-020 On an accepting edge the target unit SHALL enter EXEC and latch iss_regdest, iss_writereg; ALU/MUL SHALL load a 4-bit latency counter.
REQ-021 ALU/MUL SHALL enter DONE exactly LATENCY rising edges after the accepting edge (ALU_LATENCY=1: DONE on the next edge).
REQ-022 MEM SHALL enter DONE on the edge where mem_done=1 while MEM is in EXEC; mem_done SHALL be ignored in IDLE or DONE.
REQ-023 Each edge, if any unit is DONE, exactly one SHALL be granted by round-robin: search starts at the unit after the last granted, order ALU->MEM->MUL->ALU.
REQ-024 On a grant edge: wb_valid=1, wb_unit/wb_regdest/wb_writereg from the winner, winner returns to IDLE on that same edge; otherwise wb_valid=0 and wb_unit/wb_regdest/wb_writereg=0.
REQ-025 wb_valid SHALL be a single-cycle pulse per completed instruction; no instruction SHALL be written back twice or lost.
REQ-026 A unit freed on a grant edge SHALL be acceptable (iss_accept may be 1) in the cycle wb_valid is high.
REQ-027 Instructions with iss_writereg=0 SHALL still consume a writeback slot, with wb_writereg=0.
REQ-028 Units SHALL be non-pipelined: one outstanding instruction per unit; at most one accept per cycle.
REQ-029 A DONE unit losing arbitration SHALL hold DONE with latched regdest unchanged until granted; max wait 2 cycles.

Reset
REQ-030 While reset=0, all units SHALL be IDLE, fu_busy=000, wb_valid=0, wb_unit=0, wb_regdest=0, wb_writereg=0, counters=0.
REQ-031 Round-robin pointer SHALL reset to "last granted = MUL", so ALU has first priority.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight instructions with no writeback pulse.

Verification
REQ-033 ALU issue regdest=5, writereg=1 at edge 0 (defaults) -> fu_busy=001 after edge 0, wb_valid=1 wb_unit=0 wb_regdest=5 after edge 2, fu_busy=000 after edge 2.
REQ-034 MUL issue regdest=9 at edge 0, then MUL issue again at edges 1..4 -> iss_accept=0, iss_stall=1 until MUL freed; wb for reg 9 after edge 5; second MUL accepted in the wb cycle.
REQ-035 ALU and MUL both DONE on same edge, pointer at reset -> ALU granted first, MUL granted next edge; consecutive wb_valid cycles, wb_unit 0 then 2.
REQ-036 MEM issue regdest=12, mem_done pulsed 3 cycles later, plus spurious mem_done while MEM idle -> exactly one wb pulse for reg 12; spurious pulse ignored.
REQ-037 iss_unit=3 with iss_valid=1 -> iss_accept=0, iss_stall=1, fu_busy unchanged.
REQ-038 Reset low while all three units busy/DONE -> outputs zero immediately (asynchronous), no wb_valid after release, ALU accepted on first edge after release.

Source files
------------

// File: rtl/fu_scheduler.sv
// Functional-unit scheduler: tracks the ALU/MEM/MUL occupancy and round-robin arbitrates one writeback slot.
// Latency: issue is accepted combinationally; ALU/MUL reach DONE LATENCY edges after accept, and writeback is registered one edge after DONE.
// Backpressure: iss_stall is raised while the target unit is not IDLE (or unit 3 is presented); a DONE unit holds until granted.
// Ports:
//   clock, reset (async, active-low)
//   iss_valid/iss_unit/iss_regdest/iss_writereg -> iss_accept/iss_stall : issue handshake
//   mem_done   : MEM unit completion strobe
//   fu_busy    : per-unit occupied flags {MUL, MEM, ALU}
//   wb_valid/wb_unit/wb_regdest/wb_writereg : registered writeback slot
module fu_scheduler #(
  parameter int ALU_LATENCY = 1,
  parameter int MUL_LATENCY = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iss_valid,
  input  logic [1:0] iss_unit,
  input  logic [4:0] iss_regdest,
  input  logic       iss_writereg,
  output logic       iss_accept,
  output logic       iss_stall,
  input  logic       mem_done,
  output logic [2:0] fu_busy,
  output logic       wb_valid,
  output logic [1:0] wb_unit,
  output logic [4:0] wb_regdest,
  output logic       wb_writereg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } unit_state_t;

  localparam int         MEM_U   = 1;
  localparam logic [3:0] ALU_LAT = 4'(ALU_LATENCY);
  localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);

  unit_state_t state_q [3];
  unit_state_t state_d [3];
  logic [3:0]  cnt_q   [3];
  logic [3:0]  cnt_d   [3];
  logic [4:0]  rd_q    [3];
  logic [4:0]  rd_d    [3];
  logic        wr_q    [3];
  logic        wr_d    [3];

  // Index of the unit granted most recently; the search begins just after it.
  logic [1:0]  last_q;

  logic [2:0]  done_vec;
  // Bit 3 stands for the reserved unit code and is never idle, so it is never accepted.
  logic [3:0]  idle_vec;
  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;

  always_comb begin
    done_vec = '0;
    idle_vec = '0;
    for (int u = 0; u < 3; u++) begin
      done_vec[u] = (state_q[u] == DONE);
      idle_vec[u] = (state_q[u] == IDLE);
    end
  end

  assign fu_busy    = ~idle_vec[2:0];
  assign iss_accept = iss_valid & idle_vec[iss_unit];
  assign iss_stall  = iss_valid & ~iss_accept;

  // Round-robin: walk ALU->MEM->MUL starting after last_q, first DONE unit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!gnt_vld && done_vec[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    for (int u = 0; u < 3; u++) begin
      state_d[u] = state_q[u];
      cnt_d[u]   = cnt_q[u];
      rd_d[u]    = rd_q[u];
      wr_d[u]    = wr_q[u];
    end
    for (int u = 0; u < 3; u++) begin
      case (state_q[u])
        EXEC: begin
          if (u == MEM_U) begin
            if (mem_done) state_d[u] = DONE;
          end else if (cnt_q[u] <= 4'd1) begin
            state_d[u] = DONE;
            cnt_d[u]   = 4'd0;
          end else begin
            cnt_d[u] = cnt_q[u] - 4'd1;
          end
        end
        DONE: begin
          if (gnt_vld && gnt_idx == 2'(u)) state_d[u] = IDLE;
        end
        default: begin
          if (iss_accept && iss_unit == 2'(u)) begin
            state_d[u] = EXEC;
            cnt_d[u]   = (u == 0) ? ALU_LAT : (u == 2) ? MUL_LAT : 4'd0;
            rd_d[u]    = iss_regdest;
            wr_d[u]    = iss_writereg;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < 3; u++) begin
        state_q[u] <= IDLE;
        cnt_q[u]   <= 4'd0;
        rd_q[u]    <= 5'd0;
        wr_q[u]    <= 1'b0;
      end
      last_q      <= 2'd2;
      wb_valid    <= 1'b0;
      wb_unit     <= 2'd0;
      wb_regdest  <= 5'd0;
      wb_writereg <= 1'b0;
    end else begin
      for (int u = 0; u < 3; u++) begin
        state_q[u] <= state_d[u];
        cnt_q[u]   <= cnt_d[u];
        rd_q[u]    <= rd_d[u];
        wr_q[u]    <= wr_d[u];
      end
      if (gnt_vld) last_q <= gnt_idx;
      wb_valid    <= gnt_vld;
      wb_unit     <= gnt_vld ? gnt_idx : 2'd0;
      wb_regdest  <= gnt_vld ? rd_q[gnt_idx] : 5'd0;
      wb_writereg <= gnt_vld ? wr_q[gnt_idx] : 1'b0;
    end
  end

endmodule

// File: tb/tb_fu_scheduler.sv
// Testbench for fu_scheduler: directed scenarios plus random issue/mem_done traffic against a timestamp-based reference model.
module tb_fu_scheduler;

  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int NEVER   = 1 << 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       iss_valid;
  logic [1:0] iss_unit;
  logic [4:0] iss_regdest;
  logic       iss_writereg;
  logic       iss_accept;
  logic       iss_stall;
  logic       mem_done;
  logic [2:0] fu_busy;
  logic       wb_valid;
  logic [1:0] wb_unit;
  logic [4:0] wb_regdest;
  logic       wb_writereg;

  fu_scheduler #(.ALU_LATENCY(ALU_LAT), .MUL_LATENCY(MUL_LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_unit     (iss_unit),
    .iss_regdest  (iss_regdest),
    .iss_writereg (iss_writereg),
    .iss_accept   (iss_accept),
    .iss_stall    (iss_stall),
    .mem_done     (mem_done),
    .fu_busy      (fu_busy),
    .wb_valid     (wb_valid),
    .wb_unit      (wb_unit),
    .wb_regdest   (wb_regdest),
    .wb_writereg  (wb_writereg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int wb12_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a unit is occupied from its accept edge until its grant edge.
  // ALU/MUL finish at accept_edge + latency; MEM finishes at the edge that sees mem_done.
  // A unit is eligible for writeback at any edge strictly after its finish edge.
  int m_busy    [3];
  int m_done_at [3];
  int m_rd      [3];
  int m_wr      [3];
  int m_last;
  int edge_no = 0;
  int e_wbv, e_wbu, e_wbr, e_wbw;

  function automatic int m_accept(input int v, input int u);
    if (v == 0 || u == 3) return 0;
    return (m_busy[u] == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_done_at[i] = NEVER; m_rd[i] = 0; m_wr[i] = 0;
    end
    m_last = 2;
    e_wbv = 0; e_wbu = 0; e_wbr = 0; e_wbw = 0;
  endtask

  task automatic model_edge(input int v, input int u, input int rd, input int w, input int md);
    int acc;
    int win;
    acc = m_accept(v, u);
    win = -1;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (win < 0 && m_busy[c] != 0 && m_done_at[c] < edge_no) win = c;
    end
    if (m_busy[1] != 0 && m_done_at[1] == NEVER && md != 0) m_done_at[1] = edge_no;
    e_wbv = 0; e_wbu = 0; e_wbr = 0; e_wbw = 0;
    if (win >= 0) begin
      e_wbv = 1; e_wbu = win; e_wbr = m_rd[win]; e_wbw = m_wr[win];
      m_busy[win] = 0;
      m_done_at[win] = NEVER;
      m_last = win;
    end
    if (acc != 0) begin
      m_busy[u] = 1; m_rd[u] = rd; m_wr[u] = w;
      m_done_at[u] = (u == 0) ? edge_no + ALU_LAT : (u == 2) ? edge_no + MUL_LAT : NEVER;
    end
    edge_no++;
  endtask

  // One clock cycle: drive, check combinational handshake, clock, check registered outputs.
  task automatic step(input int v, input int u, input int rd, input int w, input int md);
    int exp_acc;
    iss_valid    = v[0];
    iss_unit     = u[1:0];
    iss_regdest  = rd[4:0];
    iss_writereg = w[0];
    mem_done     = md[0];
    #1;
    exp_acc = m_accept(v, u);
    chk("iss_accept", iss_accept, exp_acc);
    chk("iss_stall", iss_stall, (v != 0 && exp_acc == 0) ? 1 : 0);
    @(posedge clock);
    model_edge(v, u, rd, w, md);
    #1;
    chk("wb_valid", wb_valid, e_wbv);
    chk("wb_unit", wb_unit, e_wbu);
    chk("wb_regdest", wb_regdest, e_wbr);
    chk("wb_writereg", wb_writereg, e_wbw);
    chk("fu_busy", fu_busy, m_busy[0] + 2 * m_busy[1] + 4 * m_busy[2]);
    if (wb_valid && wb_regdest == 5'd12) wb12_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock edge.
  task automatic do_reset();
    iss_valid = 1'b0; iss_unit = 2'd0; iss_regdest = 5'd0; iss_writereg = 1'b0; mem_done = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_unit", wb_unit, 0);
    chk("rst_wb_regdest", wb_regdest, 0);
    chk("rst_wb_writereg", wb_writereg, 0);
    chk("rst_fu_busy", fu_busy, 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    iss_valid = 1'b0; iss_unit = 2'd0; iss_regdest = 5'd0; iss_writereg = 1'b0; mem_done = 1'b0;
    do_reset();

    // ALU single issue, default latency: busy after edge 0, writeback after edge 2.
    step(1, 0, 5, 1, 0);
    chk("alu_busy_e0", fu_busy, 3'b001);
    idle(2);
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_unit", wb_unit, 0);
    chk("alu_wb_reg", wb_regdest, 5);
    chk("alu_free", fu_busy, 0);
    idle(2);

    // MUL held busy: retries stall until the writeback cycle, then accepted.
    step(1, 2, 9, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 2, 10, 1, 0);
    chk("mul_wb_valid", wb_valid, 1);
    chk("mul_wb_reg", wb_regdest, 9);
    iss_valid = 1'b1; iss_unit = 2'd2; iss_regdest = 5'd10;
    #1;
    chk("mul_reaccept", iss_accept, 1);
    step(1, 2, 10, 1, 0);
    idle(6);

    // ALU and MUL finish together with the pointer at reset: ALU then MUL.
    do_reset();
    step(1, 2, 7, 1, 0);
    idle(2);
    step(1, 0, 3, 0, 0);
    idle(1);
    idle(1);
    chk("tie_first_unit", wb_unit, 0);
    chk("tie_first_vld", wb_valid, 1);
    idle(1);
    chk("tie_second_unit", wb_unit, 2);
    chk("tie_second_vld", wb_valid, 1);
    idle(2);

    // MEM completion with spurious mem_done while idle and after completion.
    wb12_cnt = 0;
    step(0, 0, 0, 0, 1);
    step(1, 1, 12, 1, 1);
    idle(2);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("mem_wb_count", wb12_cnt, 1);

    // Reserved unit code is never accepted.
    iss_valid = 1'b1; iss_unit = 2'd3; iss_regdest = 5'd1;
    #1;
    chk("rsv_accept", iss_accept, 0);
    chk("rsv_stall", iss_stall, 1);
    step(1, 3, 1, 1, 0);
    step(1, 3, 2, 0, 0);

    // Reset with all three units occupied, then ALU accepted right after release.
    step(1, 2, 1, 1, 0);
    step(1, 1, 2, 1, 0);
    step(1, 0, 3, 1, 0);
    idle(1);
    chk("all_busy", fu_busy, 3'b111);
    do_reset();
    iss_valid = 1'b1; iss_unit = 2'd0; iss_regdest = 5'd4;
    #1;
    chk("alu_after_reset", iss_accept, 1);
    step(1, 0, 4, 1, 0);
    chk("alu_busy_after_reset", fu_busy, 3'b001);
    idle(6);

    // Random traffic with occasional mid-run reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 31),
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
